// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS control unit: state encoding,
// instruction fields, ALU codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: aluop selects add, sub or the R-type funct mapping.
// funct_illegal reports a funct outside the supported set regardless of aluop.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  logic [2:0] w_funct_ctrl;

  always_comb begin
    w_funct_ctrl  = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  w_funct_ctrl = ALU_ADD;
      FN_SUB:  w_funct_ctrl = ALU_SUB;
      FN_AND:  w_funct_ctrl = ALU_AND;
      FN_OR:   w_funct_ctrl = ALU_OR;
      FN_SLT:  w_funct_ctrl = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = w_funct_ctrl;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore decode of state, with memory-side
// strobes qualified by mem_ready and the branch PC enable by zero.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] w_aluop;
  logic       w_funct_illegal;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_pcen;
  logic       w_irwrite;
  logic       w_retire;

  mc_aludec u_aludec (
    .funct         (funct),
    .aluop         (w_aluop),
    .alucontrol    (alucontrol),
    .funct_illegal (w_funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    iord       = 1'b0;
    memread    = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    w_pcen     = 1'b0;
    w_aluop    = ALUOP_ADD;
    w_retire   = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        memread   = 1'b1;
        alusrcb   = SRCB_FOUR;
        w_irwrite = mem_ready;
        w_pcen    = mem_ready;
        if (mem_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = w_funct_illegal ? S_ILLEGAL : S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        w_next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        w_regwrite   = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        iord       = 1'b1;
        w_retire   = mem_ready;
        if (mem_ready) w_next_state = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca      = 1'b1;
        w_aluop      = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        w_regwrite   = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        alusrca      = 1'b1;
        w_aluop      = ALUOP_SUB;
        pcsrc        = PC_ALUOUT;
        w_pcen       = zero;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        w_next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite   = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JUMP: begin
        pcsrc        = PC_JUMP;
        w_pcen       = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: w_next_state = S_ILLEGAL;
    endcase
  end

  // State-changing strobes are suppressed while reset is high so nothing
  // commits on the reset edge itself.
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign pcen     = w_pcen & ~reset;
  assign irwrite  = w_irwrite & ~reset;
  assign retire   = w_retire & ~reset;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: checks per-state decode, handshake
// stalls, instruction cycle counts, illegal handling and reset behaviour.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, retire, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .retire     (retire),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH, stalling mem_ready for the given number
  // of cycles in FETCH and in the data access, and counts cycles to retire.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fwait, input int mwait,
                           input int exp_cycles, input int exp_wb);
    int  cycles = 0;
    int  wb = 0;
    int  fw = 0;
    int  mw = 0;
    bit  done = 0;
    op = o; funct = f; zero = z;
    for (int i = 0; i < 40 && !done; i++) begin
      mem_ready = 1'b1;
      if (state == 4'd0 && fw < fwait) begin
        mem_ready = 1'b0; fw++;
      end else if ((state == 4'd3 || state == 4'd5) && mw < mwait) begin
        mem_ready = 1'b0; mw++;
      end
      #1;
      cycles++;
      if (regwrite === 1'b1) wb++;
      if (retire === 1'b1) done = 1;
      else next();
    end
    next();
    chk({name, "_cycles"}, 8'(cycles), 8'(exp_cycles));
    chk({name, "_regwrite_cycles"}, 8'(wb), 8'(exp_wb));
    chk({name, "_back_to_fetch"}, {4'd0, state}, 8'd0);
    $display("instr %s: %0d cycles, %0d regwrite cycles", name, cycles, wb);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [2:0] exp_alu);
    op = 6'b000000; funct = f; mem_ready = 1'b1;
    #1; chk("rt_fetch", {4'd0, state}, 8'd0);
    next(); chk("rt_decode", {4'd0, state}, 8'd1);
    next(); chk("rt_execute", {4'd0, state}, 8'd6);
    chk("rt_alucontrol", {5'd0, alucontrol}, {5'd0, exp_alu});
    chk("rt_srcs", {5'd0, alusrca, alusrcb}, 8'b100);
    next(); chk("rt_aluwb", {4'd0, state}, 8'd7);
    chk("rt_wb_ctrl", {4'd0, regdst, regwrite, retire, memtoreg}, 8'b1110);
    next(); chk("rt_done", {4'd0, state}, 8'd0);
    $display("instr rtype funct=%b alucontrol=%b", f, alucontrol);
  endtask

  task automatic beq(input logic z);
    op = 6'b000100; funct = 6'd0; zero = z; mem_ready = 1'b1;
    next(); chk("beq_decode", {4'd0, state}, 8'd1);
    next(); chk("beq_branch", {4'd0, state}, 8'd8);
    chk("beq_pcen", {7'd0, pcen}, {7'd0, z});
    chk("beq_pcsrc_alu", {3'd0, pcsrc, alucontrol}, {3'd0, 2'b01, 3'b110});
    chk("beq_retire", {7'd0, retire}, 8'd1);
    next();
    $display("instr beq zero=%0b pcen observed", z);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 6'b101011; funct = 6'b100000; zero = 1'b0;
    next();
    reset = 1'b0;
    #1;
    chk("reset_state", {4'd0, state}, 8'd0);
    chk("reset_memread", {7'd0, memread}, 8'd1);
    chk("reset_pcen_irwrite", {6'd0, pcen, irwrite}, 8'b11);
    chk("reset_illegal", {7'd0, illegal}, 8'd0);

    // sw with mem_ready tied high: 0,1,2,5
    next(); chk("sw_decode", {4'd0, state}, 8'd1);
    chk("sw_decode_srcb", {6'd0, alusrcb}, 8'b11);
    next(); chk("sw_memadr", {4'd0, state}, 8'd2);
    chk("sw_memadr_src", {5'd0, alusrca, alusrcb}, 8'b110);
    next(); chk("sw_memwr", {4'd0, state}, 8'd5);
    chk("sw_memwr_ctrl", {4'd0, memwrite, iord, retire, regwrite}, 8'b1110);
    next(); chk("sw_done", {4'd0, state}, 8'd0);
    $display("instr sw directed");

    // reset while a store is stalled
    next(); next(); next();
    mem_ready = 1'b0;
    #1; chk("stall_memwrite", {6'd0, memwrite, retire}, 8'b10);
    next(); chk("stall_hold", {4'd0, state, memwrite, iord}, {4'd0, 4'd5, 2'b11});
    reset = 1'b1;
    #1; chk("reset_edge_memwrite", {7'd0, memwrite}, 8'd0);
    next();
    reset = 1'b0; mem_ready = 1'b0;
    #1; chk("reset_memwr_state", {4'd0, state}, 8'd0);
    chk("reset_memwr_strobes", {5'd0, memwrite, memread, pcen}, 8'b010);
    $display("reset during MEMWR");

    run_instr("lw_stalled", 6'b100011, 6'd0, 1'b0, 2, 3, 10, 1);
    run_instr("sw", 6'b101011, 6'd0, 1'b0, 0, 0, 4, 0);
    run_instr("addi", 6'b001000, 6'd0, 1'b0, 0, 0, 4, 1);
    run_instr("rtype_add", 6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1);
    run_instr("beq", 6'b000100, 6'd0, 1'b1, 0, 0, 3, 0);
    run_instr("j", 6'b000010, 6'd0, 1'b0, 0, 0, 3, 0);
    run_instr("sw_stalled", 6'b101011, 6'd0, 1'b0, 1, 2, 7, 0);

    // addi decode
    op = 6'b001000; mem_ready = 1'b1;
    next(); next(); chk("addi_ex", {4'd0, state}, 8'd9);
    chk("addi_ex_src", {5'd0, alusrca, alusrcb}, 8'b110);
    next(); chk("addi_wb", {4'd0, state}, 8'd10);
    chk("addi_wb_ctrl", {4'd0, regdst, regwrite, memtoreg, retire}, 8'b0101);
    next();
    $display("instr addi directed");

    rtype(6'b101010, 3'b111);
    rtype(6'b100000, 3'b010);
    rtype(6'b100010, 3'b110);
    rtype(6'b100100, 3'b000);
    rtype(6'b100101, 3'b001);

    beq(1'b1);
    beq(1'b0);

    op = 6'b000010;
    next(); next(); chk("j_state", {4'd0, state}, 8'd11);
    chk("j_ctrl", {5'd0, pcsrc, pcen}, 8'b101);
    next();
    $display("instr j directed");

    // undefined opcode
    op = 6'b111111;
    next(); next(); chk("illop_state", {4'd0, state}, 8'd12);
    for (int i = 0; i < 20; i++) begin
      next();
      chk("illop_hold", {3'd0, state, illegal}, {3'd0, 4'd12, 1'b1});
    end
    chk("illop_strobes", {4'd0, memread, memwrite, pcen, retire}, 8'd0);
    reset = 1'b1; next(); reset = 1'b0; #1;
    chk("illop_cleared", {3'd0, state, illegal}, 8'd0);
    $display("instr illegal opcode");

    // undefined funct
    op = 6'b000000; funct = 6'b000111;
    next(); next(); chk("illfn_state", {3'd0, state, illegal}, {3'd0, 4'd12, 1'b1});
    reset = 1'b1; next(); reset = 1'b0; #1;
    chk("illfn_cleared", {3'd0, state, illegal}, 8'd0);
    $display("instr illegal funct");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
